// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared definitions for the RISC CPU top and the memory loader:
//            default bus widths and the loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int AWIDTH_DEFAULT = 5;
  localparam int DWIDTH_DEFAULT = 8;

  // Loader state encoding, fixed 3-bit values so the CPU top can decode them
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_WAIT = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module   : counter
// Purpose  : Loadable up-counter used as the loader address register.
//            Priority: rst, then load, then enab.
// Revision : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count
);

  // Address register: clear on reset, parallel load, or increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (enab) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/driver.sv
`default_nettype none
// ============================================================================
// Module   : driver
// Purpose  : Tristate buffer onto a shared data bus; high-Z when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output wire  [WIDTH-1:0] dout
);

  assign dout = en ? din : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Memory-bus initiator that streams a program image into memory
//            (load) or streams memory contents out (dump), covering addresses
//            0..len. Holds the CPU in reset while active.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
  import risc_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEFAULT,
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [AWIDTH-1:0] len,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              hold,
  output logic              done
);

  ld_state_t         r_state;
  ld_state_t         w_next;
  logic [AWIDTH-1:0] r_len;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_out_data;
  logic              w_clr;
  logic              w_inc;
  logic              w_last;

  // The final address is inclusive, so len = 2^AWIDTH-1 stops at the top
  // address without the counter ever wrapping.
  assign w_last   = (mem_addr == r_len);
  assign out_data = r_out_data;

  counter #(
    .WIDTH (AWIDTH)
  ) u_addr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_clr),
    .enab  (w_inc),
    .din   ({AWIDTH{1'b0}}),
    .count (mem_addr)
  );

  driver #(
    .WIDTH (DWIDTH)
  ) u_drv (
    .en   (r_state == ST_WRITE),
    .din  (r_wdata),
    .dout (mem_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operation length, write byte and dump word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_wdata    <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_len <= len;
      end
      if (r_state == ST_LOAD_WAIT && in_valid) begin
        r_wdata <= in_data;
      end
      if (r_state == ST_READ) begin
        r_out_data <= mem_data;
      end
    end
  end

  // Next-state and bus/stream outputs, all decoded from the current state
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    hold      = 1'b1;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        hold = 1'b0;
        if (start) begin
          w_clr  = 1'b1;
          w_next = mode ? ST_READ : ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_wr = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_inc  = 1'b1;
          w_next = ST_LOAD_WAIT;
        end
      end
      ST_READ: begin
        mem_rd = 1'b1;
        w_next = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_last) begin
            w_next = ST_DONE;
          end else begin
            w_inc  = 1'b1;
            w_next = ST_READ;
          end
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        hold   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Directed self-checking bench for mem_loader with a 32x8 memory
//            model on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [4:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  wire  [7:0] mem_data;
  logic       hold;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [32];
  logic [4:0] wlog_addr [256];
  logic [7:0] wlog_data [256];
  logic [7:0] olog [256];
  int wcnt = 0;
  int dcnt = 0;
  int ocnt = 0;
  int rcyc = 0;
  logic       waiting = 1'b0;
  logic [7:0] prev_out = 8'h00;

  always #5 clk = ~clk;

  mem_loader #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_data  (mem_data),
    .hold      (hold),
    .done      (done)
  );

  // Memory model: combinational read while mem_rd, write on the edge
  assign mem_data = mem_rd ? mem[mem_addr] : 8'bzzzzzzzz;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus monitor: strobe exclusivity, hold while busy, write/done/output logs
  always @(negedge clk) begin
    check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
    if (mem_rd | mem_wr | in_ready | out_valid | done)
      check("hold_busy", {31'd0, hold}, 32'd1);
    if (mem_wr) begin
      wlog_addr[wcnt & 255] = mem_addr;
      wlog_data[wcnt & 255] = mem_data;
      wcnt++;
    end
    if (done) dcnt++;
    if (out_valid) begin
      if (waiting) check("out_stable", {24'd0, out_data}, {24'd0, prev_out});
      if (out_ready) begin
        olog[ocnt & 255] = out_data;
        ocnt++;
        waiting = 1'b0;
      end else begin
        waiting  = 1'b1;
        prev_out = out_data;
      end
    end else begin
      waiting = 1'b0;
    end
  end

  // Downstream backpressure: ready one cycle in three
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      out_ready = (rcyc % 3 == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic m, input logic [4:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    step();
    start = 1'b0;
    check("hold_rise", {31'd0, hold}, 32'd1);
  endtask

  task automatic feed(input int n, input logic [7:0] base, input logic [7:0] stp);
    for (int i = 0; i < n; i++) begin
      int t;
      in_data  = base + 8'(i) * stp;
      in_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 50);
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < budget);
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int w0;
    int d0;
    int o0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; len = 5'd0;
    in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    step();

    // Load four bytes
    w0 = wcnt;
    start_op(1'b0, 5'd3);
    feed(4, 8'h11, 8'h11);
    wait_done(20);
    check("load4_writes", wcnt - w0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("load4_waddr", {27'd0, wlog_addr[(w0 + i) & 255]}, i);
      check("load4_wdata", {24'd0, wlog_data[(w0 + i) & 255]}, 32'h11 * (i + 1));
    end
    step();
    check("load4_hold_fall", {31'd0, hold}, 32'd0);
    check("load4_mem3", {24'd0, mem[3]}, 32'h44);

    // Full memory load of 0..31
    w0 = wcnt;
    d0 = dcnt;
    start_op(1'b0, 5'd31);
    feed(32, 8'h00, 8'h01);
    wait_done(20);
    check("full_writes", wcnt - w0, 32'd32);
    check("full_addr_end", {27'd0, mem_addr}, 32'd31);
    check("full_last_waddr", {27'd0, wlog_addr[(wcnt - 1) & 255]}, 32'd31);
    check("full_first_waddr", {27'd0, wlog_addr[w0 & 255]}, 32'd0);
    check("full_mem31", {24'd0, mem[31]}, 32'd31);
    step();
    check("full_done_once", dcnt - d0, 32'd1);

    // Reset in the middle of a load
    d0 = dcnt;
    start_op(1'b0, 5'd3);
    feed(2, 8'h55, 8'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_hold", {31'd0, hold}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_addr", {27'd0, mem_addr}, 32'd0);
    w0 = wcnt;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step(); step(); step();
    in_valid = 1'b0;
    check("midrst_no_done", dcnt - d0, 32'd0);
    check("idle_in_valid_ignored", wcnt - w0, 32'd0);
    check("midrst_mem0", {24'd0, mem[0]}, 32'h55);
    check("midrst_mem1", {24'd0, mem[1]}, 32'h66);
    check("midrst_mem2", {24'd0, mem[2]}, 32'h02);
    check("midrst_mem3", {24'd0, mem[3]}, 32'h03);

    // Start together with reset: reset wins
    rst = 1'b1; start = 1'b1; mode = 1'b0; len = 5'd1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_hold", {31'd0, hold}, 32'd0);

    // Fresh load with a stray start while busy
    w0 = wcnt;
    start_op(1'b0, 5'd3);
    start = 1'b1; mode = 1'b1; len = 5'd0;
    step();
    start = 1'b0;
    feed(4, 8'hC0, 8'h01);
    wait_done(20);
    check("busy_start_writes", wcnt - w0, 32'd4);
    check("fresh_mem0", {24'd0, mem[0]}, 32'hC0);
    check("fresh_mem3", {24'd0, mem[3]}, 32'hC3);
    step();

    // Preload A0..A2, then dump them with backpressure
    start_op(1'b0, 5'd2);
    feed(3, 8'hA0, 8'h01);
    wait_done(20);
    step();
    o0 = ocnt;
    start_op(1'b1, 5'd2);
    wait_done(100);
    check("dump_words", ocnt - o0, 32'd3);
    for (int i = 0; i < 3; i++)
      check("dump_data", {24'd0, olog[(o0 + i) & 255]}, 32'hA0 + i);
    check("dump_addr_end", {27'd0, mem_addr}, 32'd2);
    step();
    check("dump_hold_fall", {31'd0, hold}, 32'd0);
    check("dump_mem3_kept", {24'd0, mem[3]}, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
